vif_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one registered valid/ready/data channel among `NUM_REQ` requesters. Each requester presents a beat with a valid/ready handshake. The block picks one winner per cycle and registers the beat into a single output stage, tagging it with the winner's index. A burst limit lets the current owner keep the channel for up to `MAX_BURST` consecutive beats before priority rotates. It sits in front of a shared interface instance so multiple producers can drive it without contention.

---
 rtl/vif_rr_arbiter.sv | 73 +++++++
 tb/tb_vif_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vif_rr_arbiter.sv
// vif_rr_arbiter: round-robin arbiter with burst limit feeding one registered valid/ready/data stage
module vif_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_grant_id,
    input  logic                      out_ready
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [ID_W-1:0]   last_id;
    logic [CNT_W-1:0]  burst_cnt;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic              sticky;
    logic              can_accept;
    logic              under_limit;
    logic [DATA_W-1:0] win_data;

    assign can_accept  = reset_n && (!out_valid || out_ready);
    assign under_limit = burst_cnt < CNT_W'(MAX_BURST);
    // burst_cnt of zero means nobody owns the channel yet, so no sticky hold
    assign sticky      = req_valid[last_id] && burst_cnt != '0 && under_limit;
    assign win_data    = req_data[int'(win)*DATA_W +: DATA_W];

    // pick the winner: sticky owner first, else first valid after last_id, wrapping to last_id
    always_comb begin
        win   = last_id;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_id) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        if (sticky) win = last_id;
        req_ready = '0;
        if (can_accept && found) req_ready[win] = 1'b1;
    end

    // output register and arbitration state; everything holds under backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_grant_id <= '0;
            last_id      <= ID_W'(NUM_REQ - 1);
            burst_cnt    <= '0;
        end else if (can_accept) begin
            if (found) begin
                out_valid    <= 1'b1;
                out_data     <= win_data;
                out_grant_id <= win;
                last_id      <= win;
                burst_cnt    <= (win == last_id && under_limit) ? burst_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vif_rr_arbiter.sv
// tb_vif_rr_arbiter: table-driven directed checks of the round-robin arbiter
module tb_vif_rr_arbiter;
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_gid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_grant_id;
    logic        out_ready = 1'b1;

    vec_t vec [64];
    int   nvec = 0;
    int   checks = 0;
    int   errors = 0;

    vif_rr_arbiter dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_grant_id(out_grant_id),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [31:0] d, input logic o,
                       input logic [3:0] r, input logic ov, input logic [7:0] od, input logic [1:0] g);
        vec[nvec].valid   = v;
        vec[nvec].data    = d;
        vec[nvec].ordy    = o;
        vec[nvec].exp_rdy = r;
        vec[nvec].exp_ov  = ov;
        vec[nvec].exp_od  = od;
        vec[nvec].exp_gid = g;
        nvec++;
    endtask

    initial begin
        int g;
        // fairness from reset: four grants each, rotating
        for (int i = 0; i < 17; i++) begin
            g = (i / 4) % 4;
            add(4'hF, 32'hA3A2A1A0, 1'b1, 4'(1 << g), 1'b1, 8'(8'hA0 + g), 2'(g));
        end
        // lone requester 2 streams across the burst boundary without gaps
        for (int i = 0; i < 6; i++)
            add(4'h4, {8'h00, 8'(8'h10 + i), 16'h0000}, 1'b1, 4'h4, 1'b1, 8'(8'h10 + i), 2'd2);
        // backpressure on requester 1 while A5 sits in the output
        add(4'h2, 32'h00005000, 1'b1, 4'h2, 1'b1, 8'h50, 2'd1);
        add(4'h2, 32'h0000A500, 1'b1, 4'h2, 1'b1, 8'hA5, 2'd1);
        for (int i = 0; i < 3; i++)
            add(4'h2, 32'h0000A600, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd1);
        add(4'h2, 32'h0000A600, 1'b1, 4'h2, 1'b1, 8'hA6, 2'd1);
        // idle cycle drains the output but holds data/id
        add(4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 8'hA6, 2'd1);
        add(4'h1, 32'h000000D0, 1'b1, 4'h1, 1'b1, 8'hD0, 2'd0);
        // early release: 1 takes two beats, drops, 3 restarts its burst at 1
        add(4'hA, 32'hC000B000, 1'b1, 4'h2, 1'b1, 8'hB0, 2'd1);
        add(4'hA, 32'hC000B100, 1'b1, 4'h2, 1'b1, 8'hB1, 2'd1);
        add(4'h8, 32'hC0000000, 1'b1, 4'h8, 1'b1, 8'hC0, 2'd3);
        add(4'hA, 32'hC100B200, 1'b1, 4'h8, 1'b1, 8'hC1, 2'd3);
        add(4'hA, 32'hC200B200, 1'b1, 4'h8, 1'b1, 8'hC2, 2'd3);
        add(4'hA, 32'hC300B200, 1'b1, 4'h8, 1'b1, 8'hC3, 2'd3);
        add(4'hA, 32'hC300B200, 1'b1, 4'h2, 1'b1, 8'hB2, 2'd1);
        add(4'h4, 32'h003C0000, 1'b1, 4'h4, 1'b1, 8'h3C, 2'd2);

        // reset with every requester valid
        req_valid = 4'hF;
        req_data  = 32'hA3A2A1A0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_grant_id", 32'(out_grant_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        reset_n = 1'b1;

        // each row: drive at negedge, check ready, then registered outputs after the edge
        for (int i = 0; i < nvec; i++) begin
            req_valid = vec[i].valid;
            req_data  = vec[i].data;
            out_ready = vec[i].ordy;
            #1;
            chk($sformatf("row%0d_req_ready", i), 32'(req_ready), 32'(vec[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vec[i].exp_ov));
            chk($sformatf("row%0d_out_data", i), 32'(out_data), 32'(vec[i].exp_od));
            chk($sformatf("row%0d_grant_id", i), 32'(out_grant_id), 32'(vec[i].exp_gid));
            @(negedge clk);
        end

        // mid-stream reset discards the 3C beat asynchronously
        #2 reset_n = 1'b0;
        req_valid = 4'hC;
        req_data  = 32'h55440000;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'h00);
        chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_out_data", 32'(out_data), 32'h44);
        chk("post_rst_grant_id", 32'(out_grant_id), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
